// File: rtl/ft_rx_deframer_if.sv
// Byte-in / message-out bundle for the FT232H sync245 receive deframer.
// slave = deframer side, master = byte source / message consumer side.
interface ft_rx_deframer_if;
    logic [7:0] rx_data;
    logic       rx_avail;
    logic       rx_pull;
    logic [7:0] msg_data;
    logic       msg_valid;
    logic       msg_last;
    logic       msg_ready;
    logic       frame_ok;
    logic       frame_err;
    logic [7:0] err_count;

    modport slave (
        input  rx_data, rx_avail, msg_ready,
        output rx_pull, msg_data, msg_valid, msg_last, frame_ok, frame_err, err_count
    );

    modport master (
        output rx_data, rx_avail, msg_ready,
        input  rx_pull, msg_data, msg_valid, msg_last, frame_ok, frame_err, err_count
    );
endinterface

// File: rtl/ft_rx_deframer.sv
// Deframes SYNC/LEN/payload/CSUM packets from the sync245 byte stream, buffers the
// payload until the checksum verifies, then replays it on a valid/ready message port.
module ft_rx_deframer #(
    parameter int         MAX_LEN   = 64,
    parameter logic [7:0] SYNC_BYTE = 8'h7E,
    parameter int         TIMEOUT   = 1000
) (
    input  logic               ft_clkout,
    input  logic               ft_rstn,
    ft_rx_deframer_if.slave    bus
);

    localparam int         IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CSUM, S_DRAIN} state_e;

    state_e           state_q;
    logic [7:0]       len_q;
    logic [IDX_W-1:0] idx_q;
    logic [7:0]       csum_q;
    logic [15:0]      timer_q;
    logic             rx_pull_q;
    logic [7:0]       msg_data_q;
    logic             msg_valid_q;
    logic             msg_last_q;
    logic             frame_ok_q;
    logic             frame_err_q;
    logic [7:0]       err_cnt_q;
    logic [7:0]       mem_q [MAX_LEN];

    logic [7:0]       csum_sum;
    logic [IDX_W-1:0] idx_nx;
    logic             idx_is_last;
    logic             idx_nx_is_last;
    logic [7:0]       err_cnt_inc;

    assign csum_sum       = csum_q + bus.rx_data;
    assign idx_nx         = idx_q + IDX_W'(1);
    assign idx_is_last    = (8'(idx_q) == len_q - 8'd1);
    assign idx_nx_is_last = (8'(idx_nx) == len_q - 8'd1);
    assign err_cnt_inc    = (err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1;

    // Payload store has no reset; only bytes of the frame in flight are ever read back.
    always_ff @(posedge ft_clkout) begin
        if (state_q == S_PAYLOAD && bus.rx_avail)
            mem_q[idx_q] <= bus.rx_data;
    end

    always_ff @(posedge ft_clkout or negedge ft_rstn) begin
        if (!ft_rstn) begin
            state_q     <= S_HUNT;
            len_q       <= 8'd0;
            idx_q       <= '0;
            csum_q      <= 8'd0;
            timer_q     <= 16'd0;
            rx_pull_q   <= 1'b0;
            msg_data_q  <= 8'd0;
            msg_valid_q <= 1'b0;
            msg_last_q  <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            rx_pull_q   <= 1'b1;
            case (state_q)
                S_HUNT: begin
                    if (bus.rx_avail && bus.rx_data == SYNC_BYTE) begin
                        state_q <= S_LEN;
                        csum_q  <= 8'd0;
                        timer_q <= 16'd0;
                    end
                end
                S_LEN, S_PAYLOAD, S_CSUM: begin
                    if (bus.rx_avail) begin
                        timer_q <= 16'd0;
                        case (state_q)
                            S_LEN: begin
                                if (bus.rx_data == 8'd0 || bus.rx_data > MAX_LEN_B) begin
                                    frame_err_q <= 1'b1;
                                    err_cnt_q   <= err_cnt_inc;
                                    state_q     <= S_HUNT;
                                end else begin
                                    len_q   <= bus.rx_data;
                                    idx_q   <= '0;
                                    csum_q  <= bus.rx_data;
                                    state_q <= S_PAYLOAD;
                                end
                            end
                            S_PAYLOAD: begin
                                csum_q <= csum_sum;
                                idx_q  <= idx_nx;
                                if (idx_is_last) state_q <= S_CSUM;
                            end
                            default: begin
                                if (csum_sum == 8'h00) begin
                                    frame_ok_q <= 1'b1;
                                    idx_q      <= '0;
                                    state_q    <= S_DRAIN;
                                    rx_pull_q  <= 1'b0;
                                end else begin
                                    frame_err_q <= 1'b1;
                                    err_cnt_q   <= err_cnt_inc;
                                    state_q     <= S_HUNT;
                                end
                            end
                        endcase
                    end else if (timer_q == TO_LAST) begin
                        frame_err_q <= 1'b1;
                        err_cnt_q   <= err_cnt_inc;
                        timer_q     <= 16'd0;
                        state_q     <= S_HUNT;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                S_DRAIN: begin
                    rx_pull_q <= 1'b0;
                    // First drain cycle only loads beat 0, so msg_valid trails frame_ok by one.
                    if (!msg_valid_q) begin
                        msg_valid_q <= 1'b1;
                        msg_data_q  <= mem_q[idx_q];
                        msg_last_q  <= idx_is_last;
                    end else if (bus.msg_ready) begin
                        if (msg_last_q) begin
                            msg_valid_q <= 1'b0;
                            msg_last_q  <= 1'b0;
                            state_q     <= S_HUNT;
                            rx_pull_q   <= 1'b1;
                        end else begin
                            idx_q      <= idx_nx;
                            msg_data_q <= mem_q[idx_nx];
                            msg_last_q <= idx_nx_is_last;
                        end
                    end
                end
                default: state_q <= S_HUNT;
            endcase
        end
    end

    assign bus.rx_pull   = rx_pull_q;
    assign bus.msg_data  = msg_data_q;
    assign bus.msg_valid = msg_valid_q;
    assign bus.msg_last  = msg_last_q;
    assign bus.frame_ok  = frame_ok_q;
    assign bus.frame_err = frame_err_q;
    assign bus.err_count = err_cnt_q;

    // Source must honour rx_pull; a byte arriving while draining is lost.
    a_no_rx_in_drain: assert property (@(posedge ft_clkout) disable iff (!ft_rstn)
        !(state_q == S_DRAIN && bus.rx_avail));

endmodule

// File: tb/tb_ft_rx_deframer.sv
// Directed bench for ft_rx_deframer: a stream-level frame predictor feeds expected
// events and message beats; a negedge monitor compares the DUT against them.
module tb_ft_rx_deframer;
    localparam int         MAX_LEN = 64;
    localparam int         TIMEOUT = 1000;
    localparam logic [7:0] SYNC    = 8'h7E;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ft_rx_deframer_if bus();

    ft_rx_deframer #(.MAX_LEN(MAX_LEN), .SYNC_BYTE(SYNC), .TIMEOUT(TIMEOUT)) dut (
        .ft_clkout (clk),
        .ft_rstn   (rst_n),
        .bus       (bus.slave)
    );

    int n_chk = 0;
    int n_err = 0;

    typedef enum int {EV_NONE, EV_OK, EV_ERR} ev_e;
    ev_e        exp_evt[$];
    logic [8:0] exp_msg[$];
    int         mdl_err = 0;
    logic [7:0] stim[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Walk a byte stream by the framing rules; a stream ending mid-frame means idle -> timeout.
    function automatic void predict(input logic [7:0] s[$]);
        int n = s.size();
        int i = 0;
        int len;
        logic [7:0] sum;
        while (i < n) begin
            if (s[i] != SYNC) begin i++; continue; end
            i++;
            if (i >= n) begin exp_evt.push_back(EV_ERR); return; end
            len = int'(s[i]);
            i++;
            if (len == 0 || len > MAX_LEN) begin exp_evt.push_back(EV_ERR); continue; end
            if (i + len + 1 > n) begin exp_evt.push_back(EV_ERR); return; end
            sum = 8'(len);
            for (int k = 0; k <= len; k++) sum = sum + s[i+k];
            if (sum == 8'h00) begin
                exp_evt.push_back(EV_OK);
                for (int k = 0; k < len; k++) exp_msg.push_back({k == len - 1, s[i+k]});
            end else begin
                exp_evt.push_back(EV_ERR);
            end
            i += len + 1;
        end
    endfunction

    // Monitor
    logic       pv_stall = 1'b0;
    logic       pv_ok    = 1'b0;
    logic [7:0] pv_data  = 8'd0;
    logic       pv_last  = 1'b0;
    always @(negedge clk) begin
        ev_e        ev;
        logic [9:0] m;
        if (!rst_n) begin
            pv_stall = 1'b0;
            pv_ok    = 1'b0;
            mdl_err  = 0;
        end else begin
            if (bus.frame_ok || bus.frame_err)
                chk("ok_err_exclusive", 32'(bus.frame_ok & bus.frame_err), 32'd0);
            if (bus.frame_ok) begin
                ev = (exp_evt.size() > 0) ? exp_evt.pop_front() : EV_NONE;
                chk("frame_ok_event", 32'(ev), 32'(EV_OK));
            end
            if (bus.frame_err) begin
                ev = (exp_evt.size() > 0) ? exp_evt.pop_front() : EV_NONE;
                chk("frame_err_event", 32'(ev), 32'(EV_ERR));
                mdl_err++;
                chk("err_count_on_err", 32'(bus.err_count), 32'((mdl_err > 255) ? 255 : mdl_err));
            end
            if (pv_ok) chk("valid_after_ok", 32'(bus.msg_valid), 32'd1);
            if (bus.msg_valid) chk("pull_low_in_drain", 32'(bus.rx_pull), 32'd0);
            if (pv_stall)
                chk("stall_stable", 32'({bus.msg_valid, bus.msg_last, bus.msg_data}),
                    32'({1'b1, pv_last, pv_data}));
            if (bus.msg_valid && bus.msg_ready) begin
                m = (exp_msg.size() > 0) ? {1'b0, exp_msg.pop_front()} : 10'h3FF;
                chk("msg_beat", 32'({1'b0, bus.msg_last, bus.msg_data}), 32'(m));
            end
            pv_stall = bus.msg_valid && !bus.msg_ready;
            pv_ok    = bus.frame_ok;
            pv_data  = bus.msg_data;
            pv_last  = bus.msg_last;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [7:0] s[$]);
        predict(s);
        foreach (s[i]) begin
            bus.rx_avail = 1'b1;
            bus.rx_data  = s[i];
            tick();
        end
        bus.rx_avail = 1'b0;
        bus.rx_data  = 8'd0;
    endtask

    task automatic first_beat(input string nm, input logic [7:0] d, input logic l);
        int n = 0;
        while (!bus.msg_valid && n < 20) begin @(negedge clk); n++; end
        chk({nm, "_seen"}, 32'(bus.msg_valid), 32'd1);
        chk({nm, "_data"}, 32'(bus.msg_data), 32'(d));
        chk({nm, "_last"}, 32'(bus.msg_last), 32'(l));
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        @(negedge clk);
        while (!(bus.rx_pull && !bus.msg_valid) && n < 300) begin @(negedge clk); n++; end
        chk({nm, "_idle"}, 32'(bus.rx_pull && !bus.msg_valid), 32'd1);
        chk({nm, "_drained"}, 32'(exp_msg.size()), 32'd0);
        tick();
    endtask

    initial begin
        int idle;
        bit found;
        bus.rx_data   = 8'd0;
        bus.rx_avail  = 1'b0;
        bus.msg_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rx_pull",   32'(bus.rx_pull),   32'd0);
        chk("rst_msg_valid", 32'(bus.msg_valid), 32'd0);
        chk("rst_msg_last",  32'(bus.msg_last),  32'd0);
        chk("rst_msg_data",  32'(bus.msg_data),  32'd0);
        chk("rst_frame_ok",  32'(bus.frame_ok),  32'd0);
        chk("rst_frame_err", 32'(bus.frame_err), 32'd0);
        chk("rst_err_count", 32'(bus.err_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("pull_first_cycle", 32'(bus.rx_pull), 32'd0);
        tick();
        chk("pull_second_cycle", 32'(bus.rx_pull), 32'd1);

        // Good 3-byte frame
        stim = '{8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
        send(stim);
        first_beat("good1", 8'h11, 1'b0);
        wait_idle("good1");
        chk("good1_err_count", 32'(bus.err_count), 32'd0);

        // Bad checksum, then the good frame again
        stim = '{8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h98};
        send(stim);
        wait_idle("badcs");
        chk("badcs_err_count", 32'(bus.err_count), 32'd1);
        chk("badcs_events", 32'(exp_evt.size()), 32'd0);
        stim = '{8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
        send(stim);
        first_beat("good2", 8'h11, 1'b0);
        wait_idle("good2");

        // Garbage before sync, single-beat payload
        stim = '{8'h00, 8'hFF, 8'h55, 8'h7E, 8'h01, 8'hAA, 8'h55};
        send(stim);
        first_beat("single", 8'hAA, 1'b1);
        wait_idle("single");
        chk("single_err_count", 32'(bus.err_count), 32'd1);

        // LEN=0 and LEN=MAX_LEN+1
        stim = '{8'h7E, 8'h00, 8'h7E, 8'h41};
        send(stim);
        wait_idle("badlen");
        chk("badlen_err_count", 32'(bus.err_count), 32'd3);
        chk("badlen_events", 32'(exp_evt.size()), 32'd0);

        // Back-pressure for 20 cycles
        bus.msg_ready = 1'b0;
        stim = '{8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
        send(stim);
        first_beat("stall", 8'h11, 1'b0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("stall_data", 32'({bus.msg_valid, bus.msg_data}), 32'({1'b1, 8'h11}));
            chk("stall_pull", 32'(bus.rx_pull), 32'd0);
        end
        tick();
        bus.msg_ready = 1'b1;
        wait_idle("stall");

        // Truncated frame -> timeout
        stim = '{8'h7E, 8'h05, 8'h01};
        send(stim);
        found = 1'b0;
        idle  = -1;
        for (int k = 1; k <= TIMEOUT + 5 && !found; k++) begin
            @(negedge clk);
            if (bus.frame_err) begin found = 1'b1; idle = k - 1; end
        end
        chk("timeout_seen", 32'(found), 32'd1);
        chk("timeout_idle_cycles", 32'(idle), 32'(TIMEOUT));
        tick();
        chk("timeout_err_count", 32'(bus.err_count), 32'd4);

        // Reset in the middle of a drain
        bus.msg_ready = 1'b0;
        stim = '{8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
        send(stim);
        first_beat("middrain", 8'h11, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid",    32'(bus.msg_valid), 32'd0);
        chk("mid_rst_last",     32'(bus.msg_last),  32'd0);
        chk("mid_rst_data",     32'(bus.msg_data),  32'd0);
        chk("mid_rst_ok",       32'(bus.frame_ok),  32'd0);
        chk("mid_rst_err",      32'(bus.frame_err), 32'd0);
        chk("mid_rst_errcount", 32'(bus.err_count), 32'd0);
        chk("mid_rst_pull",     32'(bus.rx_pull),   32'd0);
        exp_msg.delete();
        exp_evt.delete();
        tick();
        tick();
        rst_n = 1'b1;
        bus.msg_ready = 1'b1;
        @(negedge clk);
        chk("rerst_pull_first", 32'(bus.rx_pull), 32'd0);
        tick();
        chk("rerst_pull_second", 32'(bus.rx_pull), 32'd1);
        stim = '{8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
        send(stim);
        first_beat("after_rst", 8'h11, 1'b0);
        wait_idle("after_rst");
        chk("after_rst_err_count", 32'(bus.err_count), 32'd0);

        chk("final_events_left", 32'(exp_evt.size()), 32'd0);
        chk("final_msgs_left",   32'(exp_msg.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
